// File: rtl/ex_stage_md_pkg.sv
// rtl/ex_stage_md_pkg.sv - shared types and op-class helpers for the execute stage
`timescale 1ns/1ps
package ex_stage_md_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLL    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_SLT    = 4'd8,
        ALU_SLTU   = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // MUL only returns the low half, which is sign-agnostic, so it runs unsigned.
    function automatic logic md_signed_a(input md_op_e op);
        return op inside {MULH, MULHSU, DIV, REM};
    endfunction

    function automatic logic md_signed_b(input md_op_e op);
        return op inside {MULH, DIV, REM};
    endfunction

    function automatic logic md_is_div(input md_op_e op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

endpackage

// File: rtl/ex_stage_md_md_iter.sv
// rtl/ex_stage_md_md_iter.sv - radix-2 iterative multiply/divide unit with start/done handshake
`timescale 1ns/1ps
module md_iter_unit
    import ex_stage_md_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  start,
    input  md_op_e                op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  out_free,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    md_state_e             state;
    logic [CNT_W-1:0]      count;
    md_op_e                op_q;
    logic                  neg_a;
    logic                  neg_b;
    logic                  div0;
    logic                  ovf;
    logic [DATA_WIDTH-1:0] a_raw;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
    logic [DATA_WIDTH-1:0] b_mag;

    logic                  sa;
    logic                  sb;
    logic [DATA_WIDTH-1:0] a_abs;
    logic [DATA_WIDTH-1:0] b_abs;
    logic [DATA_WIDTH:0]   add_sum;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH+1:0] diff;

    assign sa    = md_signed_a(op) & a[DATA_WIDTH-1];
    assign sb    = md_signed_b(op) & b[DATA_WIDTH-1];
    assign a_abs = sa ? -a : a;
    assign b_abs = sb ? -b : b;

    // hi:lo is the product accumulator for multiply and remainder:quotient for divide.
    assign add_sum = {1'b0, hi} + {1'b0, b_mag};
    assign shifted = {hi, lo[DATA_WIDTH-1]};
    assign diff    = {1'b0, shifted} - {2'b00, b_mag};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MD_IDLE;
            busy  <= 1'b0;
            count <= '0;
            op_q  <= MUL;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            div0  <= 1'b0;
            ovf   <= 1'b0;
            a_raw <= '0;
            hi    <= '0;
            lo    <= '0;
            b_mag <= '0;
        end else if (flush) begin
            state <= MD_IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        state <= MD_RUN;
                        busy  <= 1'b1;
                        count <= '0;
                        op_q  <= op;
                        neg_a <= sa;
                        neg_b <= sb;
                        div0  <= (b == '0);
                        ovf   <= md_signed_b(op) & md_is_div(op) & (a == MOST_NEG) & (b == '1);
                        a_raw <= a;
                        hi    <= '0;
                        lo    <= a_abs;
                        b_mag <= b_abs;
                    end
                end
                MD_RUN: begin
                    if (md_is_div(op_q)) begin
                        if (!diff[DATA_WIDTH+1]) begin
                            hi <= diff[DATA_WIDTH-1:0];
                            lo <= {lo[DATA_WIDTH-2:0], 1'b1};
                        end else begin
                            hi <= shifted[DATA_WIDTH-1:0];
                            lo <= {lo[DATA_WIDTH-2:0], 1'b0};
                        end
                    end else if (lo[0]) begin
                        hi <= add_sum[DATA_WIDTH:1];
                        lo <= {add_sum[0], lo[DATA_WIDTH-1:1]};
                    end else begin
                        hi <= {1'b0, hi[DATA_WIDTH-1:1]};
                        lo <= {hi[0], lo[DATA_WIDTH-1:1]};
                    end
                    count <= count + CNT_W'(1);
                    if (count == LAST) begin
                        state <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    if (out_free) begin
                        state <= MD_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    logic [2*DATA_WIDTH-1:0] prod_fix;
    logic [DATA_WIDTH-1:0]   quot;
    logic [DATA_WIDTH-1:0]   rem;

    assign prod_fix = (neg_a ^ neg_b) ? -{hi, lo} : {hi, lo};
    assign quot     = (neg_a ^ neg_b) ? -lo : lo;
    assign rem      = neg_a ? -hi : hi;

    always_comb begin
        result = '0;
        case (op_q)
            MUL:                  result = prod_fix[DATA_WIDTH-1:0];
            MULH, MULHSU, MULHU:  result = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            DIV, DIVU:            result = div0 ? '1 : (ovf ? a_raw : quot);
            REM, REMU:            result = div0 ? a_raw : (ovf ? '0 : rem);
            default:              result = '0;
        endcase
    end

    assign done = (state == MD_DONE) & out_free & !flush;

endmodule

// File: rtl/ex_stage_md.sv
// rtl/ex_stage_md.sv - execute stage: forwarding, single-cycle ALU, iterative MD, valid/ready output register
`timescale 1ns/1ps
module ex_stage_md
    import ex_stage_md_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_W     = 8,
    parameter bit MD_EN      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  flush_i,
    input  logic [1:0]            fwd_a_sel_i,
    input  logic [1:0]            fwd_b_sel_i,
    input  logic                  op_a_src_i,
    input  logic                  op_b_src_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] mem_fwd_data_i,
    input  logic [DATA_WIDTH-1:0] wb_fwd_data_i,
    input  logic [3:0]            alu_op_i,
    input  logic                  md_en_i,
    input  logic [2:0]            md_op_i,
    input  logic [4:0]            rd_add_i,
    input  logic                  regwrite_i,
    input  logic [CTRL_W-1:0]     ctrl_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  zero_o,
    output logic [DATA_WIDTH-1:0] store_data_o,
    output logic [DATA_WIDTH-1:0] branch_target_o,
    output logic [4:0]            rd_add_o,
    output logic                  regwrite_o,
    output logic [CTRL_W-1:0]     ctrl_o,
    output logic                  busy_o
);

    localparam int SH_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] fwd_a;
    logic [DATA_WIDTH-1:0] fwd_b;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] alu_res;
    logic [DATA_WIDTH-1:0] issue_res;
    logic [DATA_WIDTH-1:0] md_res;
    logic [SH_W-1:0]       shamt;
    logic                  out_free;
    logic                  accept;
    logic                  md_start;
    logic                  alu_accept;
    logic                  md_busy;
    logic                  md_done;

    always_comb begin
        fwd_a = rs1_data_i;
        case (fwd_sel_e'(fwd_a_sel_i))
            FWD_MEM: fwd_a = mem_fwd_data_i;
            FWD_WB:  fwd_a = wb_fwd_data_i;
            default: fwd_a = rs1_data_i;
        endcase
    end

    always_comb begin
        fwd_b = rs2_data_i;
        case (fwd_sel_e'(fwd_b_sel_i))
            FWD_MEM: fwd_b = mem_fwd_data_i;
            FWD_WB:  fwd_b = wb_fwd_data_i;
            default: fwd_b = rs2_data_i;
        endcase
    end

    assign op_a  = op_a_src_i ? pc_i : fwd_a;
    assign op_b  = op_b_src_i ? imm_i : fwd_b;
    assign shamt = op_b[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        case (alu_op_e'(alu_op_i))
            ALU_ADD:    alu_res = op_a + op_b;
            ALU_SUB:    alu_res = op_a - op_b;
            ALU_AND:    alu_res = op_a & op_b;
            ALU_OR:     alu_res = op_a | op_b;
            ALU_XOR:    alu_res = op_a ^ op_b;
            ALU_SLL:    alu_res = op_a << shamt;
            ALU_SRL:    alu_res = op_a >> shamt;
            ALU_SRA:    alu_res = $signed(op_a) >>> shamt;
            ALU_SLT:    alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:   alu_res = {{(DATA_WIDTH-1){1'b0}}, op_a < op_b};
            ALU_PASS_B: alu_res = op_b;
            default:    alu_res = '0;
        endcase
    end

    // Without the MD unit an MD op takes the single-cycle path and yields zero.
    assign issue_res  = md_en_i ? '0 : alu_res;
    assign out_free   = !out_valid_o | out_ready_i;
    assign in_ready_o = !flush_i & !md_busy & out_free;
    assign accept     = in_valid_i & in_ready_o;
    assign md_start   = accept & md_en_i & MD_EN;
    assign alu_accept = accept & !md_start;
    assign busy_o     = md_busy;

    generate
        if (MD_EN) begin : g_md
            md_iter_unit #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_md (
                .clk      (clk),
                .rst      (rst),
                .flush    (flush_i),
                .start    (md_start),
                .op       (md_op_e'(md_op_i)),
                .a        (op_a),
                .b        (op_b),
                .out_free (out_free),
                .busy     (md_busy),
                .done     (md_done),
                .result   (md_res)
            );
        end else begin : g_no_md
            assign md_busy = 1'b0;
            assign md_done = 1'b0;
            assign md_res  = '0;
        end
    endgenerate

    // Side-band of an MD op, captured at accept and released with its result.
    logic [DATA_WIDTH-1:0] hold_store;
    logic [DATA_WIDTH-1:0] hold_bt;
    logic [4:0]            hold_rd;
    logic                  hold_wr;
    logic [CTRL_W-1:0]     hold_ctrl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_store <= '0;
            hold_bt    <= '0;
            hold_rd    <= '0;
            hold_wr    <= 1'b0;
            hold_ctrl  <= '0;
        end else if (md_start) begin
            hold_store <= fwd_b;
            hold_bt    <= pc_i + imm_i;
            hold_rd    <= rd_add_i;
            hold_wr    <= regwrite_i;
            hold_ctrl  <= ctrl_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_o     <= 1'b0;
            result_o        <= '0;
            zero_o          <= 1'b0;
            store_data_o    <= '0;
            branch_target_o <= '0;
            rd_add_o        <= '0;
            regwrite_o      <= 1'b0;
            ctrl_o          <= '0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (alu_accept) begin
            out_valid_o     <= 1'b1;
            result_o        <= issue_res;
            zero_o          <= (issue_res == '0);
            store_data_o    <= fwd_b;
            branch_target_o <= pc_i + imm_i;
            rd_add_o        <= rd_add_i;
            regwrite_o      <= regwrite_i;
            ctrl_o          <= ctrl_i;
        end else if (md_done) begin
            out_valid_o     <= 1'b1;
            result_o        <= md_res;
            zero_o          <= (md_res == '0);
            store_data_o    <= hold_store;
            branch_target_o <= hold_bt;
            rd_add_o        <= hold_rd;
            regwrite_o      <= hold_wr;
            ctrl_o          <= hold_ctrl;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage_md.sv
// tb/tb_ex_stage_md.sv - directed bench for ex_stage_md with hand-computed expectations
`timescale 1ns/1ps
module tb_ex_stage_md;
    import ex_stage_md_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic        op_a_src;
    logic        op_b_src;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] mem_fwd_data;
    logic [31:0] wb_fwd_data;
    logic [3:0]  alu_op;
    logic        md_en;
    logic [2:0]  md_op;
    logic [4:0]  rd_add;
    logic        regwrite;
    logic [7:0]  ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic [31:0] store_data;
    logic [31:0] branch_target;
    logic [4:0]  rd_add_q;
    logic        regwrite_q;
    logic [7:0]  ctrl_q;
    logic        busy;

    int checks = 0;
    int errors = 0;

    ex_stage_md #(
        .DATA_WIDTH(32),
        .CTRL_W(8),
        .MD_EN(1'b1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .flush_i         (flush),
        .fwd_a_sel_i     (fwd_a_sel),
        .fwd_b_sel_i     (fwd_b_sel),
        .op_a_src_i      (op_a_src),
        .op_b_src_i      (op_b_src),
        .rs1_data_i      (rs1_data),
        .rs2_data_i      (rs2_data),
        .imm_i           (imm),
        .pc_i            (pc),
        .mem_fwd_data_i  (mem_fwd_data),
        .wb_fwd_data_i   (wb_fwd_data),
        .alu_op_i        (alu_op),
        .md_en_i         (md_en),
        .md_op_i         (md_op),
        .rd_add_i        (rd_add),
        .regwrite_i      (regwrite),
        .ctrl_i          (ctrl),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .result_o        (result),
        .zero_o          (zero),
        .store_data_o    (store_data),
        .branch_target_o (branch_target),
        .rd_add_o        (rd_add_q),
        .regwrite_o      (regwrite_q),
        .ctrl_o          (ctrl_q),
        .busy_o          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic md, input alu_op_e aop, input md_op_e mop,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        md_en    = md;
        alu_op   = aop;
        md_op    = mop;
        rs1_data = a;
        rs2_data = b;
    endtask

    // Issues one MD op, waits for its result and checks latency, front-end stall and side-band.
    task automatic run_md(input string tag, input md_op_e mop, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int lat;
        int bcnt;
        issue(1'b1, ALU_ADD, mop, a, b);
        rd_add = 5'd9;
        @(negedge clk);
        in_valid = 1'b0;
        md_en    = 1'b0;
        rd_add   = 5'd0;
        rs1_data = '0;
        rs2_data = '0;
        lat  = 0;
        bcnt = 0;
        while (!out_valid && lat < 100) begin
            if (busy && !in_ready) bcnt++;
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'd33);
        chk({tag, " busy cycles"}, 32'(bcnt), 32'd33);
        chk({tag, " result"}, result, exp);
        chk({tag, " rd"}, 32'(rd_add_q), 32'd9);
    endtask

    initial begin
        int stale;
        rst = 1'b1;
        in_valid = 1'b0; flush = 1'b0; fwd_a_sel = 2'b00; fwd_b_sel = 2'b00;
        op_a_src = 1'b0; op_b_src = 1'b0; rs1_data = '0; rs2_data = '0;
        imm = 32'h10; pc = 32'h100; mem_fwd_data = '0; wb_fwd_data = '0;
        alu_op = ALU_ADD; md_en = 1'b0; md_op = MUL; rd_add = 5'd3;
        regwrite = 1'b1; ctrl = 8'hA5; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset rd", 32'(rd_add_q), 32'd0);
        chk("reset branch_target", branch_target, 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(1'b0, ALU_ADD, MUL, 32'd5, 32'd7);
        @(negedge clk);
        chk("add valid", 32'(out_valid), 32'd1);
        chk("add result", result, 32'd12);
        chk("add zero", 32'(zero), 32'd0);
        chk("add store_data", store_data, 32'd7);
        chk("add branch_target", branch_target, 32'h110);
        chk("add rd", 32'(rd_add_q), 32'd3);
        chk("add ctrl", 32'(ctrl_q), 32'hA5);
        issue(1'b0, ALU_ADD, MUL, 32'd1, 32'd2);
        @(negedge clk);
        chk("b2b valid 2", 32'(out_valid), 32'd1);
        chk("b2b result 2", result, 32'd3);
        issue(1'b0, ALU_SUB, MUL, 32'd5, 32'd5);
        @(negedge clk);
        chk("b2b valid 3", 32'(out_valid), 32'd1);
        chk("sub result", result, 32'd0);
        chk("sub zero", 32'(zero), 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain valid", 32'(out_valid), 32'd0);

        issue(1'b0, ALU_ADD, MUL, 32'd3, 32'd0);
        fwd_a_sel = 2'b01; mem_fwd_data = 32'd100; op_b_src = 1'b1; imm = 32'hFFFF_FFFC;
        @(negedge clk);
        in_valid = 1'b0; mem_fwd_data = 32'd500;
        chk("fwd result", result, 32'd96);
        chk("fwd branch_target", branch_target, 32'h0000_00FC);
        @(negedge clk);
        chk("fwd result held", result, 32'd96);
        fwd_a_sel = 2'b00; op_b_src = 1'b0; imm = 32'h10;

        run_md("mulh", MULH, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF);
        run_md("mulhu", MULHU, 32'h8000_0000, 32'd2, 32'h0000_0001);
        run_md("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        run_md("mul", MUL, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFD6);
        run_md("div by zero", DIV, 32'd7, 32'd0, 32'hFFFF_FFFF);
        run_md("rem by zero", REM, 32'd7, 32'd0, 32'd7);
        run_md("div overflow", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_md("rem overflow", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_md("div neg", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_md("rem neg", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_md("divu", DIVU, 32'd100, 32'd7, 32'd14);
        run_md("remu", REMU, 32'd100, 32'd7, 32'd2);

        in_valid = 1'b0;
        @(negedge clk);
        issue(1'b0, ALU_ADD, MUL, 32'd10, 32'd20);
        rd_add = 5'd4; out_ready = 1'b0;
        @(negedge clk);
        issue(1'b0, ALU_ADD, MUL, 32'd99, 32'd1);
        rd_add = 5'd6;
        for (int i = 0; i < 5; i++) begin
            chk("stall valid", 32'(out_valid), 32'd1);
            chk("stall result", result, 32'd30);
            chk("stall rd", 32'(rd_add_q), 32'd4);
            chk("stall in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("reload valid", 32'(out_valid), 32'd1);
        chk("reload result", result, 32'd100);
        chk("reload rd", 32'(rd_add_q), 32'd6);
        in_valid = 1'b0;
        @(negedge clk);
        chk("reload drain", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        run_md("mul stalled", MUL, 32'd3, 32'd4, 32'd12);
        for (int i = 0; i < 5; i++) begin
            chk("md stall valid", 32'(out_valid), 32'd1);
            chk("md stall result", result, 32'd12);
            chk("md stall in_ready", 32'(in_ready), 32'd0);
            chk("md stall busy", 32'(busy), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("md stall drain", 32'(out_valid), 32'd0);

        issue(1'b1, ALU_ADD, DIV, 32'd100, 32'd3);
        @(negedge clk);
        in_valid = 1'b0; md_en = 1'b0;
        repeat (10) @(negedge clk);
        chk("run busy", 32'(busy), 32'd1);
        flush = 1'b1;
        issue(1'b0, ALU_ADD, MUL, 32'd50, 32'd50);
        #1;
        chk("flush in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("flush valid", 32'(out_valid), 32'd0);
        chk("flush busy", 32'(busy), 32'd0);
        flush = 1'b0;
        issue(1'b0, ALU_ADD, MUL, 32'd1, 32'd1);
        #1;
        chk("post flush in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("post flush valid", 32'(out_valid), 32'd1);
        chk("post flush result", result, 32'd2);
        in_valid = 1'b0;
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("no stale md result", 32'(stale), 32'd0);

        issue(1'b1, ALU_ADD, MULHU, 32'd5, 32'd5);
        @(negedge clk);
        in_valid = 1'b0; md_en = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst result", result, 32'd0);
        chk("async rst rd", 32'(rd_add_q), 32'd0);
        chk("async rst valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("after rst in_ready", 32'(in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage_md.md
Name: ex_stage_md

Overview:
- Parametrised successor of the execute stage. It adds a valid/ready pipeline handshake and an operand-capture register.
- It adds an iterative multiply/divide unit (RV32M op set), which stalls the front end while running.
- It sits between the ID/EX register and the MEM stage.
- It keeps single-cycle ALU execution, forwarding muxes and the registered branch-target output.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be even and ≥8.
- CTRL_W, 8, width of opaque side-band control (mem op, rd/wb select) carried to MEM.
- MD_EN, 1, 1 = multiply/divide unit present; 0 = MD ops complete in 1 cycle with result 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  issue slot valid.
- in_ready_o  out  1  stage accepts issue this cycle.
- flush_i  in  1  kill in-flight op and output register.
- fwd_a_sel_i  in  2  operand A forward: 00 regfile, 01 MEM, 10 WB, 11 regfile.
- fwd_b_sel_i  in  2  operand B forward: same encoding as fwd_a_sel_i.
- op_a_src_i  in  1  0 = forwarded rs1, 1 = pc.
- op_b_src_i  in  1  0 = forwarded rs2, 1 = imm.
- rs1_data_i, rs2_data_i, imm_i, pc_i  in  DATA_WIDTH each  operands.
- mem_fwd_data_i, wb_fwd_data_i  in  DATA_WIDTH each  forward sources.
- alu_op_i  in  4  ALU control, ALU encoding.
- md_en_i  in  1  op is multiply/divide.
- md_op_i  in  3  md_op_e.
- rd_add_i  in  5  destination register.
- regwrite_i  in  1  writes rd.
- ctrl_i  in  CTRL_W  side-band control.
- out_valid_o  out  1  result register valid.
- out_ready_i  in  1  MEM accepts.
- result_o  out  DATA_WIDTH  ALU/MD result.
- zero_o  out  1  result == 0.
- store_data_o  out  DATA_WIDTH  forwarded rs2 value.
- branch_target_o  out  DATA_WIDTH  pc_i + imm_i, registered.
- rd_add_o  out  5  registered rd_add_i.
- regwrite_o  out  1  registered regwrite_i.
- ctrl_o  out  CTRL_W  registered ctrl_i.
- busy_o  out  1  MD FSM not IDLE.

Behaviour:
- Reset: every registered output is 0; FSM goes to IDLE. After reset, in_ready_o=1 and busy_o=0.
- Handshake:
  - Accept = in_valid_i & in_ready_o.
  - in_ready_o = !flush_i & state==IDLE & (!out_valid_o | out_ready_i).
  - Output register advances only when it is empty or out_ready_i=1.
  - While out_valid_o & !out_ready_i, every output is held stable.
- Forwarding: fwd/src muxes are resolved in the accept cycle only; the resulting operands are captured. Forward data is not sampled after accept.
- ALU op (md_en_i=0): result is registered at the accept edge; out_valid_o=1 the next cycle (latency 1). Back-to-back issue is allowed at full rate.
- MD FSM states:
  - IDLE: accept with md_en_i=1 → RUN. Latch |a|, |b|, signs, op and side-band; count=0.
  - RUN:
    - one radix-2 step per cycle (shift-add multiply / restoring divide); count++.
    - count==DATA_WIDTH-1 → DONE.
  - DONE:
    - apply sign correction and select hi/lo or quotient/remainder;
    - load output register when it is free (empty or out_ready_i);
    - then → IDLE. If the output register is not free, stay in DONE.
  - Fixed latency: accept at edge T; out_valid_o rises after edge T+DATA_WIDTH+1 when the output is unblocked.
- MD arithmetic:
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half of the 2·DATA_WIDTH product.
  - MULHSU treats op A as signed and op B as unsigned.
- MD special cases (latency unchanged):
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (most-negative / −1): quotient = dividend; remainder = 0.
- MD_EN=0: an MD op behaves as an ALU op with result 0.
- Flush:
  - Synchronous, highest priority; clears out_valid_o and returns FSM to IDLE.
  - A same-cycle in_valid_i is not accepted.
  - Data registers may keep stale values.
- Simultaneous events: output consumed (out_ready_i) and new accept in the same cycle → the register reloads; no bubble.
- Async rst mid-RUN: immediate return to IDLE; outputs are 0.

Decomposition:
- pkg gains:
  - md_op_e (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU);
  - fwd_sel_e (FWD_RF, FWD_MEM, FWD_WB);
  - md_state_e (MD_IDLE, MD_RUN, MD_DONE).
- Reuse the existing ALU.
- One sub-module, md_iter_unit, contains the FSM, iteration counter and shift registers. It has a start/done handshake and its own special-case handling.

Test Plan:
- ADD rs1=5, rs2=7, fwd 00, out_ready=1 → next cycle out_valid=1, result=12, zero=0; three back-to-back issues give three consecutive valid outputs.
- rs1=3 with fwd_a=01, mem_fwd=100, op_b_src=1, imm=−4 → result=96. Changing mem_fwd after accept does not alter the result.
- MULH a=0x80000000, b=2 (DATA_WIDTH=32) → busy for 33 cycles with in_ready=0, result=0xFFFFFFFF. MULHU on the same operands → 0x00000001.
- DIV 7/0 → 0xFFFFFFFF; REM 7/0 → 7; DIV 0x80000000/−1 → 0x80000000; REM → 0. Every case has latency 33.
- out_ready=0 for 5 cycles with a valid ALU result → outputs stable, in_ready=0. An MD op finishing meanwhile waits in DONE and appears the cycle after out_ready rises.
- flush during RUN (count=10) → out_valid=0, busy=0 next cycle. A subsequent ADD 1+1 → result=2 after 1 cycle.
